// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port round-robin arbiter for the shared 512x32 synchronous RAM
//
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   M0_* / M1_*         : master ports (A, I, WR, REQ, LOCK in; ACK, RDY, O out)
//   A, I, WR, CS        : RAM address, write data, write enable, chip select
//   O                   : RAM read data (valid one cycle after an enabled read edge)
module mem_arb #(
    parameter int LOCK_MAX = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] M0_A,
    input  logic [31:0] M0_I,
    input  logic        M0_WR,
    input  logic        M0_REQ,
    input  logic        M0_LOCK,
    output logic        M0_ACK,
    output logic        M0_RDY,
    output logic [31:0] M0_O,
    input  logic [31:0] M1_A,
    input  logic [31:0] M1_I,
    input  logic        M1_WR,
    input  logic        M1_REQ,
    input  logic        M1_LOCK,
    output logic        M1_ACK,
    output logic        M1_RDY,
    output logic [31:0] M1_O,
    output logic [31:0] A,
    output logic [31:0] I,
    output logic        WR,
    output logic        CS,
    input  logic [31:0] O
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = LOCK_MAX[7:0];

    state_t     state;
    logic       last;
    logic [7:0] lcnt;
    logic       rd_own;
    logic       rd_pend;

    logic       gnt_vld;
    logic       gnt;
    logic       sel_wr;
    logic       sel_lock;
    logic [7:0] lcnt_inc;

    // Grant decision; RESET suppresses any grant so CS and both ACKs stay low.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        if (!RESET) begin
            case (state)
                ARB: begin
                    if (M0_REQ && M1_REQ) begin
                        gnt_vld = 1'b1;
                        gnt     = ~last;
                    end else if (M0_REQ) begin
                        gnt_vld = 1'b1;
                        gnt     = 1'b0;
                    end else if (M1_REQ) begin
                        gnt_vld = 1'b1;
                        gnt     = 1'b1;
                    end
                end
                LOCK0: begin
                    gnt_vld = M0_REQ;
                    gnt     = 1'b0;
                end
                LOCK1: begin
                    gnt_vld = M1_REQ;
                    gnt     = 1'b1;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt     = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sel_wr   = gnt ? M1_WR   : M0_WR;
        sel_lock = gnt ? M1_LOCK : M0_LOCK;
        A        = gnt ? M1_A    : M0_A;
        I        = gnt ? M1_I    : M0_I;
        WR       = gnt_vld & sel_wr;
        CS       = gnt_vld;
        M0_ACK   = gnt_vld & ~gnt;
        M1_ACK   = gnt_vld & gnt;
        // Saturating increment so a long lock never wraps the counter.
        lcnt_inc = (lcnt == 8'hff) ? lcnt : lcnt + 8'd1;
    end

    // rd_pend is masked during RESET so a read accepted just before reset yields no RDY.
    assign M0_RDY = rd_pend & ~rd_own & ~RESET;
    assign M1_RDY = rd_pend & rd_own & ~RESET;
    assign M0_O   = O;
    assign M1_O   = O;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ARB;
            last    <= 1'b1;
            lcnt    <= 8'd0;
            rd_pend <= 1'b0;
            rd_own  <= 1'b0;
        end else begin
            rd_pend <= gnt_vld & ~sel_wr;
            if (gnt_vld && !sel_wr) begin
                rd_own <= gnt;
            end
            if (gnt_vld) begin
                last <= gnt;
            end
            case (state)
                ARB: begin
                    if (gnt_vld && sel_lock) begin
                        lcnt <= 8'd1;
                        // A limit of one means the lock already expires with this grant.
                        if (LOCK_LIMIT > 8'd1) begin
                            state <= gnt ? LOCK1 : LOCK0;
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    if (!gnt_vld) begin
                        // Owner dropped REQ: release now, nobody granted this cycle.
                        state <= ARB;
                    end else if (sel_lock) begin
                        lcnt <= lcnt_inc;
                        // Forced release; last already points at the owner, so the
                        // other port wins the next tie.
                        if (lcnt_inc >= LOCK_LIMIT) begin
                            state <= ARB;
                        end
                    end else begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with a RAM model and reference model
module tb_mem_arb;

    localparam int LM = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] M0_A, M0_I, M1_A, M1_I;
    logic        M0_WR, M0_REQ, M0_LOCK, M1_WR, M1_REQ, M1_LOCK;
    logic        M0_ACK, M0_RDY, M1_ACK, M1_RDY;
    logic [31:0] M0_O, M1_O;
    logic [31:0] A, I, O;
    logic        WR, CS;

    int n_pass  = 0;
    int n_total = 0;

    mem_arb #(.LOCK_MAX(LM)) dut (
        .CLK(CLK), .RESET(RESET),
        .M0_A(M0_A), .M0_I(M0_I), .M0_WR(M0_WR), .M0_REQ(M0_REQ), .M0_LOCK(M0_LOCK),
        .M0_ACK(M0_ACK), .M0_RDY(M0_RDY), .M0_O(M0_O),
        .M1_A(M1_A), .M1_I(M1_I), .M1_WR(M1_WR), .M1_REQ(M1_REQ), .M1_LOCK(M1_LOCK),
        .M1_ACK(M1_ACK), .M1_RDY(M1_RDY), .M1_O(M1_O),
        .A(A), .I(I), .WR(WR), .CS(CS), .O(O)
    );

    always #5 CLK = ~CLK;

    // 512x32 write-first synchronous RAM standing in for mem.
    logic [31:0] ram [512];
    initial begin
        for (int k = 0; k < 512; k++) ram[k] = 32'h0;
        ram[1] = 32'h0400c000;
    end
    always @(posedge CLK) begin
        if (CS) begin
            if (WR) begin
                ram[A[8:0]] <= I;
                O           <= I;
            end else begin
                O <= ram[A[8:0]];
            end
        end
    end

    // Reference model: who owns a lock (-1 none), how many grants it has had,
    // who was served last, and what read result is due next cycle.
    int          m_lock, m_lcnt, m_last, m_own;
    bit          m_pend;
    logic [31:0] m_rdata;
    logic [31:0] m_mem [512];

    typedef struct {
        bit          rst;
        bit          q0, l0, w0;
        logic [31:0] a0, d0;
        bit          q1, l1, w1;
        logic [31:0] a1, d1;
        bit [4:0]    e;      // ack0 ack1 cs rdy0 rdy1
        logic [31:0] eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit q0, bit l0, bit w0, logic [31:0] a0, logic [31:0] d0,
                                bit q1, bit l1, bit w1, logic [31:0] a1, logic [31:0] d1,
                                bit [4:0] e, logic [31:0] eo);
        vec_t v;
        v.rst = rst; v.q0 = q0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.e = e; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t v);
        RESET   = v.rst;
        M0_REQ  = v.q0; M0_LOCK = v.l0; M0_WR = v.w0; M0_A = v.a0; M0_I = v.d0;
        M1_REQ  = v.q1; M1_LOCK = v.l1; M1_WR = v.w1; M1_A = v.a1; M1_I = v.d1;
    endtask

    task automatic model_reset();
        m_lock = -1; m_last = 1; m_lcnt = 0; m_pend = 0; m_own = 0;
    endtask

    function automatic int model_grant();
        bit rq[2];
        rq[0] = M0_REQ; rq[1] = M1_REQ;
        if (RESET) return -1;
        if (m_lock >= 0) return rq[m_lock] ? m_lock : -1;
        if (rq[0] && rq[1]) return 1 - m_last;
        if (rq[0]) return 0;
        if (rq[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        bit          wr, lk;
        logic [31:0] a, d;
        if (RESET) begin
            model_reset();
            return;
        end
        if (g < 0) begin
            if (m_lock >= 0) m_lock = -1;
            m_pend = 0;
            return;
        end
        wr = (g == 0) ? M0_WR : M1_WR;
        lk = (g == 0) ? M0_LOCK : M1_LOCK;
        a  = (g == 0) ? M0_A : M1_A;
        d  = (g == 0) ? M0_I : M1_I;
        m_last = g;
        if (wr) begin
            m_mem[a[8:0]] = d;
            m_pend = 0;
        end else begin
            m_pend  = 1;
            m_own   = g;
            m_rdata = m_mem[a[8:0]];
        end
        if (m_lock < 0) begin
            if (lk) begin
                m_lcnt = 1;
                if (m_lcnt < LM) m_lock = g;
            end
        end else if (lk) begin
            m_lcnt = (m_lcnt < 255) ? m_lcnt + 1 : 255;
            if (m_lcnt >= LM) m_lock = -1;
        end else begin
            m_lock = -1;
        end
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic run_cycle(input bit use_tbl, input vec_t v, input int idx, output int g);
        bit e_rdy0, e_rdy1;
        #4;
        g = model_grant();
        if (use_tbl) begin
            chk($sformatf("t%0d_ack0", idx), M0_ACK, v.e[4]);
            chk($sformatf("t%0d_ack1", idx), M1_ACK, v.e[3]);
            chk($sformatf("t%0d_cs", idx), CS, v.e[2]);
            chk($sformatf("t%0d_rdy0", idx), M0_RDY, v.e[1]);
            chk($sformatf("t%0d_rdy1", idx), M1_RDY, v.e[0]);
            if (v.e[4]) chk($sformatf("t%0d_addr", idx), A, v.a0);
            if (v.e[3]) chk($sformatf("t%0d_addr", idx), A, v.a1);
            if (v.e[1]) chk($sformatf("t%0d_o0", idx), M0_O, v.eo);
            if (v.e[0]) chk($sformatf("t%0d_o1", idx), M1_O, v.eo);
        end else begin
            e_rdy0 = !RESET && m_pend && (m_own == 0);
            e_rdy1 = !RESET && m_pend && (m_own == 1);
            chk($sformatf("r%0d_ack0", idx), M0_ACK, g == 0);
            chk($sformatf("r%0d_ack1", idx), M1_ACK, g == 1);
            chk($sformatf("r%0d_cs", idx), CS, g >= 0);
            chk($sformatf("r%0d_rdy0", idx), M0_RDY, e_rdy0);
            chk($sformatf("r%0d_rdy1", idx), M1_RDY, e_rdy1);
            if (g >= 0) begin
                chk($sformatf("r%0d_addr", idx), A, (g == 0) ? M0_A : M1_A);
                chk($sformatf("r%0d_wr", idx), WR, (g == 0) ? M0_WR : M1_WR);
                if (WR) chk($sformatf("r%0d_wdata", idx), I, (g == 0) ? M0_I : M1_I);
            end
            if (e_rdy0) chk($sformatf("r%0d_o0", idx), M0_O, m_rdata);
            if (e_rdy1) chk($sformatf("r%0d_o1", idx), M1_O, m_rdata);
        end
        model_update(g);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int          g;
        bit          pr[2], pw[2], pl[2];
        logic [31:0] pa[2], pd[2];
        vec_t        v;

        for (int k = 0; k < 512; k++) m_mem[k] = 32'h0;
        m_mem[1] = 32'h0400c000;
        m_rdata  = 32'h0;
        model_reset();

        //              rst q0 l0 w0 a0     d0  q1 l1 w1 a1     d1            ack0/ack1/cs/rdy0/rdy1
        tbl.push_back(mk(1, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b00000, 0));
        tbl.push_back(mk(1, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00000, 0));
        // port 0 alone reads preloaded word
        tbl.push_back(mk(0, 1,0,0, 32'h001, 0,   0,0,0, 32'h000, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00010, 32'h0400c000));
        // both ports reading from reset release alternate
        tbl.push_back(mk(1, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00000, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b01110, 32'h0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b10101, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b01110, 32'h0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00001, 32'h0400c000));
        // write by port 1 then read-after-write by port 0
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,1, 32'h040, 32'h12345678, 5'b01100, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h040, 0,   0,0,0, 32'h000, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00010, 32'h12345678));
        // port 1 lock limited to 4 grants, then port 0, then port 1 again
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01100, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01101, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01101, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01101, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b10101, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01110, 32'h0));
        // lock owner drops REQ: idle cycle even though port 0 waits
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00001, 32'h0400c000));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00010, 32'h0));
        // port 0 locked, port 1 ignored, port 0 drops: idle then port 1
        tbl.push_back(mk(0, 1,1,0, 32'h001, 0,   0,0,0, 32'h000, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 1,1,0, 32'h001, 0,   1,0,0, 32'h000, 0,            5'b10110, 32'h0400c000));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,0, 32'h000, 0,            5'b00010, 32'h0400c000));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,0, 32'h000, 0,            5'b01100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00001, 32'h0));
        // reset right after a port 1 read accept: no RDY, port 0 first afterwards
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b01100, 0));
        tbl.push_back(mk(1, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b00000, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b01110, 32'h0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00001, 32'h0400c000));
        // reset while port 1 holds a lock
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b01100, 0));
        tbl.push_back(mk(1, 0,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b00000, 0));
        tbl.push_back(mk(0, 1,0,0, 32'h000, 0,   1,1,0, 32'h001, 0,            5'b10100, 0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   1,0,0, 32'h001, 0,            5'b01110, 32'h0));
        tbl.push_back(mk(0, 0,0,0, 32'h000, 0,   0,0,0, 32'h000, 0,            5'b00001, 32'h0400c000));

        @(posedge CLK);
        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            run_cycle(1'b1, tbl[k], k, g);
        end

        // Randomized traffic: each master holds its operation until accepted.
        for (int p = 0; p < 2; p++) begin
            pr[p] = 0; pw[p] = 0; pl[p] = 0; pa[p] = 0; pd[p] = 0;
        end
        for (int k = 0; k < 800; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p] && $urandom_range(0, 9) < 6) begin
                    pr[p]     = 1;
                    pw[p]     = ($urandom_range(0, 2) == 0);
                    pa[p]     = $urandom;
                    pa[p][8:0] = 9'($urandom_range(0, 15));
                    pd[p]     = $urandom;
                end
                if (pr[p]) pl[p] = ($urandom_range(0, 2) != 0);
            end
            v = mk(($urandom_range(0, 59) == 0),
                   pr[0], pl[0], pw[0], pa[0], pd[0],
                   pr[1], pl[1], pw[1], pa[1], pd[1], 5'b0, 0);
            drive(v);
            run_cycle(1'b0, v, k, g);
            if (g >= 0) pr[g] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares the single-port 512x32 synchronous block RAM (`mem`) between the CPU bus master (port 0) and a second master (port 1, e.g. the monitor/loader or a DMA engine). It selects one request per cycle and drives the RAM's `A`/`I`/`WR`/`CS`. It returns read data with a one-cycle `RDY` strobe to the owner and enforces round-robin fairness with a bounded bus-lock feature. It sits between the masters and `mem`; `mem` itself is unchanged.

## Interface
- `LOCK_MAX`, 8: maximum consecutive locked grants to one master before the lock is forcibly released (1..255).
- `CLK` in 1: system clock; all state updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `M0_A` in 32: port 0 word address (RAM uses bits 8:0).
- `M0_I` in 32: port 0 write data.
- `M0_WR` in 1: port 0 write (1) / read (0).
- `M0_REQ` in 1: port 0 request; held with A/I/WR stable until `M0_ACK`.
- `M0_LOCK` in 1: port 0 requests continued ownership after this grant.
- `M0_ACK` out 1: combinational; request accepted this cycle.
- `M0_RDY` out 1: registered; read data valid on `M0_O` this cycle.
- `M0_O` out 32: read data (RAM `O`, qualified by `M0_RDY`).
- `M1_*`: identical set for port 1.
- `A` out 32, `I` out 32, `WR` out 1, `CS` out 1: to RAM.
- `O` in 32: RAM read data (valid one cycle after an enabled read edge).

## Operation
- States: `ARB`, `LOCK0`, `LOCK1`. Registers: `last` (last granted port), `lcnt` (8-bit lock counter), `rd_own` (0/1), `rd_pend`.
- `ARB`: only one REQ high -> grant it. Both high -> grant the port != `last`. None -> `CS`=0, no ACK.
- On grant to port n: `A`/`I`/`WR` are muxed from port n, `CS`=1, `Mn_ACK`=1, and `last`<=n.
- Grant with `Mn_LOCK`=1 in `ARB`: next state `LOCKn`, `lcnt`<=1.
- `LOCKn`: only port n may be granted; other port's REQ is ignored (no ACK).
- In `LOCKn`, a grant to n with `LOCK`=1 does `lcnt`<=`lcnt`+1. When the incremented value reaches `LOCK_MAX`, return to `ARB` and `last`<=n, so the other port wins the next tie.
- In `LOCKn`, a grant to n with `LOCK`=0 -> `ARB`.
- In `LOCKn`, `Mn_REQ`=0 -> `ARB` in the same cycle: no grant that cycle, and the release is visible next cycle.
- A read grant sets `rd_pend`<=1 and `rd_own`<=n. A write grant or no grant sets `rd_pend`<=0.
- `Mn_RDY` = `rd_pend` && (`rd_own`==n). `M0_O` = `M1_O` = `O`.
- Back-to-back operation: a master keeping REQ high after ACK issues a new operation every granted cycle. Reads pipeline with one RDY per read.
- `lcnt` saturates; no wrap. `LOCK_MAX`=1 means a lock never extends past one grant.

## Timing
- Grant/ACK: same cycle as REQ, combinational from REQ, `last` and state.
- Read latency: RDY and data one cycle after ACK. A write followed next cycle by a read of the same address returns the new data (RAM is WRITE_FIRST).
- During `RESET`=1: `CS`=0, both ACK=0, both RDY=0.
- Reset values: state `ARB`, `last`=1 (port 0 wins the first tie), `lcnt`=0, `rd_pend`=0, `rd_own`=0.
- Reset mid-read: a read ACKed in the cycle before reset gets no RDY.
- Reset while locked: lock is dropped; first post-reset tie goes to port 0.
- Simultaneous REQ in `ARB` with `last`=n: port !n granted; the other waits exactly one cycle if it stays requesting.

## Test plan
- Port 0 only, read addr 0x001 preloaded 0x0400c000 -> `M0_ACK`=1 same cycle; next cycle `M0_RDY`=1 with `M0_O`=0x0400c000; `M1_RDY`=0 throughout.
- Both ports continuously reading 0x000 / 0x001 from reset release -> ACK order M0,M1,M0,M1; RDY alternates accordingly with data 0x00000000 / 0x0400c000.
- M1 writes 0x12345678 to 0x040, M0 reads 0x040 the next cycle -> `M0_O`=0x12345678 with `M0_RDY`.
- `LOCK_MAX`=4, M1 REQ+LOCK held 6 cycles, M0 REQ held -> M1 ACKed 4 consecutive cycles, then M0 ACKed, then M1 again.
- M0 locked, then drops REQ with M1 requesting -> one idle cycle (`CS`=0), then `M1_ACK`=1.
- `RESET` asserted the cycle after an M1 read ACK -> `M1_RDY` stays 0; after release with both requesting, M0 is granted first.
